mem_wb_stage: RTL and testbench

- Memory-to-writeback stage. Sits directly downstream of the data memory.
- Captures each instruction leaving the memory stage and selects its writeback value: load data for LOAD, ALU result otherwise.
- Buffers up to DEPTH results in an in-order queue and presents them to the register-file write port with a valid/ready handshake.
- Provides a forwarding tap to the execute stage and retire/load counters for debug.

---
 rtl/mem_wb_stage.sv | 133 +++++++++++++
 tb/tb_mem_wb_stage.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// Memory-to-writeback stage: selects load data or ALU result, queues up to DEPTH
// results in order, and drives the register-file write port plus a forwarding tap.
module mem_wb_stage #(
    parameter int              DATA_W  = 32,
    parameter int              REG_AW  = 5,
    parameter int              OP_W    = 6,
    parameter logic [OP_W-1:0] LOAD_OP = OP_W'(6'b000100),
    parameter int              DEPTH   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_d2,
    input  logic [OP_W-1:0]   opcode_d2,
    input  logic [REG_AW-1:0] rd_d2,
    input  logic              reg_we_d2,
    input  logic [DATA_W-1:0] alu_out_d2,
    input  logic [DATA_W-1:0] DOut,
    input  logic              flush,
    output logic              in_ready,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic              wb_we,
    output logic [REG_AW-1:0] wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_rd,
    output logic [DATA_W-1:0] fwd_data,
    output logic [31:0]       retired_count,
    output logic [31:0]       load_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] data;
        logic              we;
        logic              is_load;
    } entry_t;

    entry_t            entry_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [31:0]       retired_q, retired_d;
    logic [31:0]       loads_q, loads_d;

    entry_t new_entry;
    entry_t head;
    logic   push;
    logic   pop;

    // Gated by reset so upstream never sees a ready stage while it is held in reset.
    assign in_ready = !reset && (count_q < DEPTH_C);
    assign push     = valid_d2 && in_ready && !flush;
    assign pop      = wb_valid && wb_ready && !flush;

    always_comb begin
        new_entry         = '0;
        new_entry.rd      = rd_d2;
        new_entry.is_load = (opcode_d2 == LOAD_OP);
        new_entry.data    = new_entry.is_load ? DOut : alu_out_d2;
        new_entry.we      = reg_we_d2 && (rd_d2 != '0);
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        retired_d = retired_q;
        loads_d   = loads_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop) begin
                rd_ptr_d  = rd_ptr_q + PTR_W'(1);
                retired_d = retired_q + 32'd1;
                if (head.is_load) loads_d = loads_q + 32'd1;
            end
            if (push && !pop)      count_d = count_q + CNT_W'(1);
            else if (pop && !push) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            retired_q <= '0;
            loads_q   <= '0;
            for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            retired_q <= retired_d;
            loads_q   <= loads_d;
            if (push) entry_q[wr_ptr_q] <= new_entry;
        end
    end

    assign head          = entry_q[rd_ptr_q];
    assign wb_valid      = (count_q != '0);
    assign wb_we         = wb_valid && head.we;
    assign wb_rd         = wb_valid ? head.rd   : '0;
    assign wb_data       = wb_valid ? head.data : '0;
    assign retired_count = retired_q;
    assign load_count    = loads_q;

    // Walk oldest to youngest so the last writing match (the youngest) wins.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx       = '0;
        fwd_valid = 1'b0;
        fwd_rd    = '0;
        fwd_data  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr_q + PTR_W'(k);
            if ((CNT_W'(k) < count_q) && entry_q[idx].we) begin
                fwd_valid = 1'b1;
                fwd_rd    = entry_q[idx].rd;
                fwd_data  = entry_q[idx].data;
            end
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: vector table plus hand sequences for
// backpressure, forwarding, flush and asynchronous reset, with a pop scoreboard.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid_d2 = 1'b0;
    logic [5:0]  opcode_d2 = '0;
    logic [4:0]  rd_d2 = '0;
    logic        reg_we_d2 = 1'b0;
    logic [31:0] alu_out_d2 = '0;
    logic [31:0] DOut = '0;
    logic        flush = 1'b0;
    logic        in_ready;
    logic        wb_valid;
    logic        wb_ready = 1'b0;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic [31:0] retired_count;
    logic [31:0] load_count;

    mem_wb_stage dut (
        .clk(clk), .reset(reset), .valid_d2(valid_d2), .opcode_d2(opcode_d2),
        .rd_d2(rd_d2), .reg_we_d2(reg_we_d2), .alu_out_d2(alu_out_d2), .DOut(DOut),
        .flush(flush), .in_ready(in_ready), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .fwd_valid(fwd_valid),
        .fwd_rd(fwd_rd), .fwd_data(fwd_data), .retired_count(retired_count),
        .load_count(load_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        we;
        logic        ld;
    } exp_t;

    typedef struct {
        logic [5:0]  op;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] alu;
        logic [31:0] dout;
        logic [31:0] x_data;
        logic        x_we;
        logic        x_ld;
    } vec_t;

    exp_t        sb[$];
    exp_t        pend;
    vec_t        vecs[6];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_retired = '0;
    logic [31:0] exp_loads = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [5:0] op, input logic [4:0] rd, input logic we,
                         input logic [31:0] alu, input logic [31:0] dout,
                         input logic [31:0] x_data, input logic x_we, input logic x_ld);
        valid_d2   = 1'b1;
        opcode_d2  = op;
        rd_d2      = rd;
        reg_we_d2  = we;
        alu_out_d2 = alu;
        DOut       = dout;
        pend       = '{rd: rd, data: x_data, we: x_we, ld: x_ld};
    endtask

    task automatic idle();
        valid_d2 = 1'b0;
    endtask

    // One clock: observe at the falling edge, then step past the rising edge.
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        chk("occupancy", {31'd0, wb_valid}, {31'd0, sb.size() != 0});
        chk("in_ready_occ", {31'd0, in_ready}, {31'd0, sb.size() < 2});
        if (wb_valid && wb_ready && !flush) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pop: got rd=%0d expected no entry", wb_rd);
            end else begin
                e = sb.pop_front();
                $display("pop rd=%0d data=0x%0h we=%0b", wb_rd, wb_data, wb_we);
                chk("pop_rd", {27'd0, wb_rd}, {27'd0, e.rd});
                chk("pop_data", wb_data, e.data);
                chk("pop_we", {31'd0, wb_we}, {31'd0, e.we});
                exp_retired++;
                if (e.ld) exp_loads++;
            end
        end
        if (valid_d2 && in_ready && !flush) sb.push_back(pend);
        if (flush) sb.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{6'b000000, 5'd3,  1'b1, 32'h1234,     32'hDEAD, 32'h1234,     1'b1, 1'b0};
        vecs[1] = '{6'b000100, 5'd5,  1'b1, 32'h1,        32'h4,    32'h4,        1'b1, 1'b1};
        vecs[2] = '{6'b000000, 5'd0,  1'b1, 32'h55,       32'h0,    32'h55,       1'b0, 1'b0};
        vecs[3] = '{6'b000101, 5'd9,  1'b0, 32'h77,       32'h66,   32'h77,       1'b0, 1'b0};
        vecs[4] = '{6'b000100, 5'd0,  1'b1, 32'h8,        32'h99,   32'h99,       1'b0, 1'b1};
        vecs[5] = '{6'b111111, 5'd31, 1'b1, 32'hFFFFFFFF, 32'h0,    32'hFFFFFFFF, 1'b1, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_wb_we", {31'd0, wb_we}, 32'd0);
        chk("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_fwd_valid", {31'd0, fwd_valid}, 32'd0);
        chk("rst_fwd_data", fwd_data, 32'd0);
        chk("rst_retired", retired_count, 32'd0);
        chk("rst_loads", load_count, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("release_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Vector table: one instruction at a time, drained immediately.
        wb_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(vecs[i].op, vecs[i].rd, vecs[i].we, vecs[i].alu, vecs[i].dout,
                  vecs[i].x_data, vecs[i].x_we, vecs[i].x_ld);
            cycle();
            idle();
            chk("vec_wb_valid", {31'd0, wb_valid}, 32'd1);
            chk("vec_wb_rd", {27'd0, wb_rd}, {27'd0, vecs[i].rd});
            chk("vec_wb_data", wb_data, vecs[i].x_data);
            chk("vec_wb_we", {31'd0, wb_we}, {31'd0, vecs[i].x_we});
            chk("vec_fwd_valid", {31'd0, fwd_valid}, {31'd0, vecs[i].x_we});
            cycle();
            chk("vec_retired", retired_count, exp_retired);
            chk("vec_loads", load_count, exp_loads);
        end
        chk("table_retired", retired_count, 32'd6);
        chk("table_loads", load_count, 32'd2);

        // Streaming: push every cycle while popping every cycle.
        for (int i = 0; i < 4; i++) begin
            drive(6'b000000, 5'(10 + i), 1'b1, 32'h100 + 32'(i), 32'h0, 32'h100 + 32'(i), 1'b1, 1'b0);
            cycle();
            chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
        end
        idle();
        cycle();
        chk("stream_drained", {31'd0, wb_valid}, 32'd0);

        // Backpressure: fill, hold a third upstream, then drain in order.
        wb_ready = 1'b0;
        drive(6'b000000, 5'd1, 1'b1, 32'h11, 32'h0, 32'h11, 1'b1, 1'b0);
        cycle();
        drive(6'b000000, 5'd2, 1'b1, 32'h22, 32'h0, 32'h22, 1'b1, 1'b0);
        cycle();
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        chk("full_head_rd", {27'd0, wb_rd}, 32'd1);
        chk("full_fwd_rd", {27'd0, fwd_rd}, 32'd2);
        chk("full_fwd_data", fwd_data, 32'h22);
        drive(6'b000000, 5'd3, 1'b1, 32'h33, 32'h0, 32'h33, 1'b1, 1'b0);
        cycle();
        chk("held_in_ready", {31'd0, in_ready}, 32'd0);
        chk("held_head_rd", {27'd0, wb_rd}, 32'd1);
        wb_ready = 1'b1;
        cycle();
        chk("freed_in_ready", {31'd0, in_ready}, 32'd1);
        chk("freed_head_rd", {27'd0, wb_rd}, 32'd2);
        wb_ready = 1'b0;
        cycle();
        idle();
        chk("refull_in_ready", {31'd0, in_ready}, 32'd0);
        wb_ready = 1'b1;
        cycle();
        chk("recover_in_ready", {31'd0, in_ready}, 32'd1);
        cycle();
        cycle();

        // Forwarding: youngest writing entry wins, non-writers are skipped.
        wb_ready = 1'b0;
        drive(6'b000000, 5'd7, 1'b1, 32'hA, 32'h0, 32'hA, 1'b1, 1'b0);
        cycle();
        drive(6'b000101, 5'd9, 1'b0, 32'hC, 32'h0, 32'hC, 1'b0, 1'b0);
        cycle();
        idle();
        chk("fwd_skip_valid", {31'd0, fwd_valid}, 32'd1);
        chk("fwd_skip_rd", {27'd0, fwd_rd}, 32'd7);
        wb_ready = 1'b1;
        #1;
        chk("fwd_in_pop_cycle", fwd_data, 32'hA);
        cycle();
        chk("fwd_after_pop", {31'd0, fwd_valid}, 32'd0);
        cycle();
        wb_ready = 1'b0;
        drive(6'b000000, 5'd7, 1'b1, 32'hA, 32'h0, 32'hA, 1'b1, 1'b0);
        cycle();
        drive(6'b000000, 5'd7, 1'b1, 32'hB, 32'h0, 32'hB, 1'b1, 1'b0);
        cycle();
        chk("fwd_youngest_data", fwd_data, 32'hB);
        chk("fwd_youngest_valid", {31'd0, fwd_valid}, 32'd1);

        // Flush with a simultaneous push (queue is full, push retried anyway).
        flush = 1'b1;
        drive(6'b000000, 5'd4, 1'b1, 32'h44, 32'h0, 32'h44, 1'b1, 1'b0);
        cycle();
        flush = 1'b0;
        idle();
        chk("flush_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("flush_fwd_valid", {31'd0, fwd_valid}, 32'd0);
        chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
        chk("flush_retired", retired_count, exp_retired);

        // Flush while empty-but-ready with a push: push must be dropped.
        flush = 1'b1;
        drive(6'b000000, 5'd8, 1'b1, 32'h88, 32'h0, 32'h88, 1'b1, 1'b0);
        cycle();
        flush = 1'b0;
        idle();
        chk("flush_push_dropped", {31'd0, wb_valid}, 32'd0);

        // Flush coinciding with a pop: the pop is not counted.
        drive(6'b000000, 5'd6, 1'b1, 32'h66, 32'h0, 32'h66, 1'b1, 1'b0);
        cycle();
        idle();
        wb_ready = 1'b1;
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        wb_ready = 1'b0;
        chk("flush_pop_retired", retired_count, 32'd15);
        chk("flush_pop_loads", load_count, 32'd2);

        // Asynchronous reset between edges with two entries queued.
        drive(6'b000000, 5'd12, 1'b1, 32'hC0, 32'h0, 32'hC0, 1'b1, 1'b0);
        cycle();
        drive(6'b000100, 5'd13, 1'b1, 32'h0, 32'hD0, 32'hD0, 1'b1, 1'b1);
        cycle();
        idle();
        #2;
        reset = 1'b1;
        #1;
        chk("arst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("arst_fwd_valid", {31'd0, fwd_valid}, 32'd0);
        chk("arst_retired", retired_count, 32'd0);
        chk("arst_loads", load_count, 32'd0);
        chk("arst_in_ready", {31'd0, in_ready}, 32'd0);
        sb.delete();
        exp_retired = '0;
        exp_loads = '0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("post_arst_in_ready", {31'd0, in_ready}, 32'd1);
        wb_ready = 1'b1;
        drive(6'b000100, 5'd6, 1'b1, 32'h0, 32'h5A, 32'h5A, 1'b1, 1'b1);
        cycle();
        idle();
        cycle();
        chk("post_arst_retired", retired_count, 32'd1);
        chk("post_arst_loads", load_count, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
